// File: rtl/serial_add_sub.sv
// Chunk-serial adder/subtractor: N = WIDTH/CHUNK cycles per operation, done pulses one cycle after the last chunk.
// No backpressure: start is taken only in IDLE or DONE and ignored while busy.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] s_d,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             mode_q;
  logic             carry;
  logic             a_msb;
  logic             b_msb;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_chk;
  logic [CHUNK-1:0] b_eff;
  logic [CHUNK-1:0] sum_chk;
  logic             carry_nx;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] b_nx;
  logic [WIDTH-1:0] res_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          state_nx = DONE;
          last     = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtract is A + ~B + 1: the +1 comes from the carry preset at accept.
  always_comb begin
    a_chk = a_sh[CHUNK-1:0];
    b_eff = mode_q ? ~b_sh[CHUNK-1:0] : b_sh[CHUNK-1:0];
    {carry_nx, sum_chk} = {1'b0, a_chk} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry};
    a_nx   = a_sh >> CHUNK;
    b_nx   = b_sh >> CHUNK;
    res_nx = (res >> CHUNK) | (WIDTH'(sum_chk) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      mode_q <= 1'b0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      s_d    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      mode_q <= mode;
      carry  <= mode;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh  <= a_nx;
      b_sh  <= b_nx;
      res   <= res_nx;
      carry <= carry_nx;
      cnt   <= cnt + 1'b1;
      if (last) begin
        // Carry-out of A + ~B + 1 is the inverse of the borrow.
        s_d  <= res_nx;
        cout <= mode_q ^ carry_nx;
        ovf  <= ((a_msb ^ b_msb) == mode_q) && (res_nx[WIDTH-1] != a_msb);
        zero <= (res_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (CHUNK 2, 8, 1) against an arithmetic reference model.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic mode_i;

  logic [2:0][7:0] s_o;
  logic [2:0] cout_o, ovf_o, zero_o, busy_o, done_o;

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] prev [3];

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .mode(mode_i),
    .s_d(s_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  serial_add_sub #(.WIDTH(8), .CHUNK(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .mode(mode_i),
    .s_d(s_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  serial_add_sub #(.WIDTH(8), .CHUNK(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .mode(mode_i),
    .s_d(s_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]),
    .busy(busy_o[2]), .done(done_o[2]));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  function automatic logic [10:0] obs(input int i);
    return {s_o[i], cout_o[i], ovf_o[i], zero_o[i]};
  endfunction

  // Result packed as {s_d, cout, ovf, zero}.
  function automatic logic [10:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic m);
    int xi, yi, sx, sy, r, rs;
    logic [7:0] s;
    logic c, o;
    xi = int'(x);
    yi = int'(y);
    sx = (xi > 127) ? xi - 256 : xi;
    sy = (yi > 127) ? yi - 256 : yi;
    if (!m) begin
      r  = xi + yi;
      c  = (r > 255);
      rs = sx + sy;
    end else begin
      r  = xi - yi;
      c  = (xi < yi);
      rs = sx - sy;
    end
    s = r[7:0];
    o = (rs > 127) || (rs < -128);
    return {s, c, o, (s == 8'h00)};
  endfunction

  task automatic do_rst();
    rst = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("rst_out[%0d]", i), {21'd0, obs(i)}, 32'd0);
      chk_eq($sformatf("rst_bd[%0d]", i), {30'd0, busy_o[i], done_o[i]}, 32'd0);
      prev[i] = '0;
    end
  endtask

  // Launch one operation and follow every masked instance through its whole timeline.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic m,
                       input logic [2:0] mask, input bit inject);
    logic [10:0] exp;
    exp = ref_op(x, y, m);
    a_i = x;
    b_i = y;
    mode_i = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_i = 8'($urandom);
    b_i = 8'($urandom);
    mode_i = 1'($urandom);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          if (c < lat(i)) begin
            chk_eq($sformatf("run_bd[%0d] c%0d %h%s%h", i, c, x, m ? "-" : "+", y),
                   {30'd0, busy_o[i], done_o[i]}, 32'h2);
            chk_eq($sformatf("hold[%0d] c%0d", i, c), {21'd0, obs(i)}, {21'd0, prev[i]});
          end else if (c == lat(i)) begin
            chk_eq($sformatf("done_bd[%0d] %h%s%h", i, x, m ? "-" : "+", y),
                   {30'd0, busy_o[i], done_o[i]}, 32'h1);
            chk_eq($sformatf("res[%0d] %h%s%h", i, x, m ? "-" : "+", y),
                   {21'd0, obs(i)}, {21'd0, exp});
          end else begin
            chk_eq($sformatf("idle_bd[%0d] c%0d", i, c), {30'd0, busy_o[i], done_o[i]}, 32'h0);
            chk_eq($sformatf("keep[%0d] c%0d", i, c), {21'd0, obs(i)}, {21'd0, exp});
          end
        end
      end
      if (inject && c == 1) begin
        start = 1'b1;
        a_i = 8'h11;
      end else if (inject && c == 2) begin
        start = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) if (mask[i]) prev[i] = exp;
  endtask

  initial begin
    int pulses;
    logic [10:0] r1, r2;

    // Reset must win over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    a_i = 8'h3C;
    b_i = 8'h05;
    mode_i = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("init_out[%0d]", i), {21'd0, obs(i)}, 32'd0);
      chk_eq($sformatf("init_bd[%0d]", i), {30'd0, busy_o[i], done_o[i]}, 32'd0);
    end
    do_rst();

    do_op(8'h3C, 8'h05, 1'b0, 3'b111, 1'b0);
    do_op(8'h05, 8'h3C, 1'b1, 3'b111, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 3'b111, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 3'b111, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 3'b111, 1'b0);

    // Start in the second RUN cycle must not disturb the in-flight operands.
    do_op(8'h3C, 8'h05, 1'b0, 3'b001, 1'b1);
    do_rst();

    // Start held high across DONE: back-to-back, one done per operation.
    r1 = ref_op(8'h3C, 8'h05, 1'b0);
    r2 = ref_op(8'h7F, 8'h01, 1'b0);
    pulses = 0;
    a_i = 8'h3C;
    b_i = 8'h05;
    mode_i = 1'b0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      tick();
      pulses += int'(done_o[0]);
      chk_eq($sformatf("b2b_excl c%0d", c), {31'd0, busy_o[0] & done_o[0]}, 32'd0);
      if (c == 4) begin
        chk_eq("b2b_done1", {31'd0, done_o[0]}, 32'd1);
        chk_eq("b2b_res1", {21'd0, obs(0)}, {21'd0, r1});
        a_i = 8'h7F;
        b_i = 8'h01;
      end else if (c == 5) begin
        chk_eq("b2b_nogap", {30'd0, busy_o[0], done_o[0]}, 32'h2);
        chk_eq("b2b_hold1", {21'd0, obs(0)}, {21'd0, r1});
        start = 1'b0;
        a_i = 8'h00;
      end else if (c == 9) begin
        chk_eq("b2b_done2", {31'd0, done_o[0]}, 32'd1);
        chk_eq("b2b_res2", {21'd0, obs(0)}, {21'd0, r2});
      end
    end
    chk_eq("b2b_pulses", pulses, 2);
    do_rst();

    // Reset in the third RUN cycle aborts and clears the previous result.
    do_op(8'h3C, 8'h05, 1'b0, 3'b111, 1'b0);
    a_i = 8'hFF;
    b_i = 8'h01;
    mode_i = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("abort_out", {21'd0, obs(0)}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      pulses += int'(done_o[0]) + int'(busy_o[0]);
      tick();
    end
    chk_eq("abort_nodone", pulses, 0);
    chk_eq("abort_keep0", {21'd0, obs(0)}, 32'd0);
    for (int i = 0; i < 3; i++) prev[i] = '0;

    do_op(8'h05, 8'h3C, 1'b1, 3'b111, 1'b0);

    for (int k = 0; k < 20; k++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 3'b111, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
